mask_index_encoder: RTL and testbench

- Sequential encoder and serializer; the inverse of the team's one-hot/binary decoders.
- Accepts an N-bit request mask over a valid/ready handshake.
- Emits the binary index of every set bit, lowest first, one per output handshake.
- Each beat also returns the matching one-hot bit, so a downstream decoder can cross-check it.
- Sits between request-collection logic and index-driven consumers, for example a mux select or a decoder input.

---
 rtl/mask_index_encoder.sv | 84 ++++++++
 tb/tb_mask_index_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mask_index_encoder.sv
// Serialises an N-bit request mask into one beat per set bit, lowest index first.
// Each beat carries the binary index, its one-hot form, its ordinal and a last flag.
module mask_index_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [W-1:0] out_seq,
  output logic         out_last,
  output logic         zero_pulse
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [W-1:0] seq;

  // Beat fields come only from pending/seq, so no input reaches an output combinationally.
  always_comb begin
    out_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) out_idx = W'(i);
    end
  end

  assign out_onehot = pending & (~pending + N'(1));
  assign out_last   = (pending != '0) && ((pending & (pending - N'(1))) == '0);
  assign out_seq    = seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      seq        <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      zero_pulse <= 1'b0;
    end else begin
      zero_pulse <= 1'b0;
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            if (in_mask != '0) begin
              pending   <= in_mask;
              seq       <= '0;
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              zero_pulse <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            pending <= pending & ~out_onehot;
            seq     <= seq + W'(1);
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_index_encoder.sv
// Directed and randomized checks of mask_index_encoder against a queue-based model
// that lists the set bits of each mask in ascending order.
module tb_mask_index_encoder;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_mask;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic [W-1:0] out_seq;
  logic         out_last;
  logic         zero_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mask_index_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_onehot(out_onehot),
    .out_seq   (out_seq),
    .out_last  (out_last),
    .zero_pulse(zero_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers a mask at posedge+1 and waits (bounded) for the accepting edge.
  task automatic applyStimulus(input logic [N-1:0] mask, output int acc_cyc);
    bit accepted;
    int waited;
    accepted = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_mask  = mask;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (in_ready === 1'b1) accepted = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_mask  = N'($urandom);
    acc_cyc  = cyc;
    checkOutput("accept_timeout", accepted, 1);
  endtask

  task automatic zero_check();
    @(negedge clk);
    checkOutput("zero_pulse_hi", zero_pulse, 1);
    checkOutput("zero_no_valid", out_valid, 0);
    checkOutput("zero_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("zero_pulse_lo", zero_pulse, 0);
    checkOutput("zero_no_valid2", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  // Expects one beat per set bit of mask, lowest first; the model is just the list of set bits.
  task automatic drain(input logic [N-1:0] mask, input int stall_pct, input int hold_first,
                       output int last_cyc);
    int q[$];
    int seq_exp;
    int budget;
    int stalled;
    for (int b = 0; b < N; b++) if (mask[b]) q.push_back(b);
    seq_exp  = 0;
    budget   = 0;
    stalled  = 0;
    last_cyc = cyc;
    while (q.size() > 0 && budget < 200) begin
      if (stalled < hold_first) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      @(negedge clk);
      checkOutput("beat_valid", out_valid, 1);
      checkOutput("beat_idx", out_idx, q[0]);
      checkOutput("beat_onehot", out_onehot, 64'(1) << q[0]);
      checkOutput("beat_seq", out_seq, seq_exp);
      checkOutput("beat_last", out_last, q.size() == 1);
      checkOutput("beat_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      if (out_ready) begin
        void'(q.pop_front());
        seq_exp++;
        last_cyc = cyc;
      end
      budget++;
    end
    checkOutput("drain_timeout", q.size(), 0);
    out_ready = 1'b0;
    checkOutput("post_valid", out_valid, 0);
    checkOutput("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int c0, c1, c2, lc;
    logic [N-1:0] m;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    #1 rst_n  = 1'b0;
    #2;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_zero_pulse", zero_pulse, 0);
    checkOutput("rst_idx", out_idx, 0);
    checkOutput("rst_onehot", out_onehot, 0);
    checkOutput("rst_seq", out_seq, 0);
    checkOutput("rst_last", out_last, 0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel_in_ready", in_ready, 1);
    checkOutput("rel_out_valid", out_valid, 0);

    $display("[TB] test 1: mask a4");
    applyStimulus(8'hA4, c0);
    drain(8'hA4, 0, 0, lc);

    $display("[TB] test 2: zero mask then 01");
    applyStimulus(8'h00, c0);
    zero_check();
    applyStimulus(8'h01, c0);
    drain(8'h01, 0, 0, lc);

    $display("[TB] test 3: mask 81 with backpressure");
    applyStimulus(8'h81, c0);
    drain(8'h81, 0, 3, lc);

    $display("[TB] test 4: mask ff back-to-back");
    applyStimulus(8'hFF, c0);
    drain(8'hFF, 0, 0, lc);
    checkOutput("ff_last_beat_cycle", lc - c0, 8);

    $display("[TB] test 5: mask 5a with ff held on input");
    applyStimulus(8'h5A, c1);
    checkOutput("ff_mask_period", c1 - c0, 9);
    in_valid = 1'b1;
    in_mask  = 8'hFF;
    drain(8'h5A, 0, 0, lc);
    applyStimulus(8'hFF, c2);
    checkOutput("held_accept_period", c2 - c1, 5);
    drain(8'hFF, 0, 0, lc);

    $display("[TB] test 6: reset mid-drain");
    applyStimulus(8'hF0, c0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_idx", out_idx, 4);
    checkOutput("mid_seq", out_seq, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_in_ready", in_ready, 0);
    checkOutput("async_idx", out_idx, 0);
    checkOutput("async_onehot", out_onehot, 0);
    checkOutput("async_seq", out_seq, 0);
    checkOutput("async_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel2_in_ready", in_ready, 1);
    checkOutput("rel2_out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_residual_beat", out_valid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(8'h02, c0);
    drain(8'h02, 0, 0, lc);

    $display("[TB] random masks with random backpressure");
    for (int r = 0; r < 25; r++) begin
      m = N'($urandom);
      if ($urandom_range(0, 3) == 0) m = '0;
      applyStimulus(m, c0);
      if (m == '0) zero_check();
      else drain(m, 40, 0, lc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
